// File: rtl/wide_add_sequencer.sv
// Multi-cycle N_SLICES*16-bit add/subtract that time-shares one 16-bit lookahead adder,
// LSB slice first, with the inter-slice carry held in a register.
module wide_add_sequencer #(
    parameter int unsigned N_SLICES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [16*N_SLICES-1:0]  op_a,
    input  logic [16*N_SLICES-1:0]  op_b,
    input  logic                    sub,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [16*N_SLICES-1:0]  result,
    output logic                    cout,
    output logic                    overflow
);

    localparam int unsigned W    = 16 * N_SLICES;
    localparam int unsigned IdxW = $clog2(N_SLICES) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_SLICES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [15:0]     a_sl, b_sl, sum_s;
    logic            sum_co;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_valid)       state_d = StRun;
            StRun:   if (idx_q == LastIdx)  state_d = StDone;
            StDone:  if (res_ready)         state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    // Outputs depend on registered state only
    always_comb begin
        start_ready = (state_q == StIdle);
        res_valid   = (state_q == StDone);
        result      = result_q;
        cout        = cout_q;
        overflow    = ovf_q;
    end

    // Select the operand slice addressed by the slice index
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < int'(N_SLICES); i++) begin
            if (idx_q == IdxW'(i)) begin
                a_sl = a_q[16*i +: 16];
                b_sl = b_q[16*i +: 16];
            end
        end
    end

    // 16-bit adder: four 4-bit groups with group-level carry lookahead
    always_comb begin : lookahead_adder
        logic [15:0] g, p, c;
        logic [3:0]  gg, gp;
        logic [4:0]  gc;
        g  = a_sl & b_sl;
        p  = a_sl ^ b_sl;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = carry_q;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | ((&p[4*k+1 +: 3]) & g[4*k]);
            gp[k] = &p[4*k +: 4];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        sum_s  = p ^ c;
        sum_co = gc[4];
    end

    // Datapath next-state
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(N_SLICES); i++) begin
                    if (idx_q == IdxW'(i)) result_d[16*i +: 16] = sum_s;
                end
                carry_d = sum_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    cout_d = sum_co;
                    // Signed overflow uses the effective (possibly inverted) B sign
                    ovf_d  = (a_q[W-1] == b_q[W-1]) & (sum_s[15] != a_q[W-1]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed vector table, hand-written corner
// sequences, and randomized operations checked against an arithmetic reference model.
module tb_wide_add_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_valid, start_ready, sub, res_valid, res_ready, cout, ovf;
    logic [63:0] op_a, op_b, result;

    logic        s1_start_valid, s1_start_ready, s1_sub, s1_res_valid, s1_res_ready;
    logic        s1_cout, s1_ovf;
    logic [15:0] s1_op_a, s1_op_b, s1_result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.N_SLICES(4)) dut (
        .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .res_valid(res_valid), .res_ready(res_ready),
        .result(result), .cout(cout), .overflow(ovf)
    );

    wide_add_sequencer #(.N_SLICES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start_valid(s1_start_valid),
        .start_ready(s1_start_ready), .op_a(s1_op_a), .op_b(s1_op_b), .sub(s1_sub),
        .res_valid(s1_res_valid), .res_ready(s1_res_ready), .result(s1_result),
        .cout(s1_cout), .overflow(s1_ovf)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; sub carry-out means "no borrow"
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
        exp_t e;
        logic [64:0] t;
        if (!s) begin
            t   = {1'b0, a} + {1'b0, b};
            e.r = t[63:0];
            e.c = t[64];
            e.v = (a[63] == b[63]) && (e.r[63] != a[63]);
        end else begin
            e.r = a - b;
            e.c = (a >= b);
            e.v = (a[63] != b[63]) && (e.r[63] != a[63]);
        end
        return e;
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input logic ack, output exp_t got, output int lat);
        int n;
        n = 0;
        while (!start_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!start_ready) chk("start_ready timeout", 64'(start_ready), 64'd1);
        op_a = a; op_b = b; sub = s; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        op_a = {$urandom(), $urandom()};
        op_b = {$urandom(), $urandom()};
        sub  = ~s;
        lat  = 0;
        while (!res_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        got.r = result; got.c = cout; got.v = ovf;
        if (ack) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
    endtask

    vec_t vecs[6];
    exp_t got, e, q[$];
    int   lat, n, last_acc, n_acc;
    logic [63:0] ra, rb;
    logic        rs;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0, 1'b0};

        reset_n = 1'b1; start_valid = 1'b0; res_ready = 1'b0; sub = 1'b0;
        op_a = '0; op_b = '0;
        s1_start_valid = 1'b0; s1_res_ready = 1'b0; s1_sub = 1'b0; s1_op_a = '0; s1_op_b = '0;
        #2 reset_n = 1'b0;
        #10;
        chk("reset start_ready", 64'(start_ready), 64'd1);
        chk("reset res_valid", 64'(res_valid), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset cout", 64'(cout), 64'd0);
        chk("reset overflow", 64'(ovf), 64'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b1, got, lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d result", i), got.r, vecs[i].res);
            chk($sformatf("vec%0d cout", i), 64'(got.c), 64'(vecs[i].co));
            chk($sformatf("vec%0d overflow", i), 64'(got.v), 64'(vecs[i].ov));
            chk($sformatf("vec%0d res_valid drop", i), 64'(res_valid), 64'd0);
        end

        // Hold in DONE with res_ready low and new requests pending
        e = model(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0, got, lat);
        chk("hold initial result", got.r, e.r);
        start_valid = 1'b1; op_a = 64'hDEAD_BEEF_0000_0001; op_b = 64'h5; sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold res_valid", 64'(res_valid), 64'd1);
            chk("hold start_ready", 64'(start_ready), 64'd0);
            chk("hold result", result, e.r);
            chk("hold flags", {62'd0, cout, ovf}, {62'd0, e.c, e.v});
        end
        start_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("release res_valid", 64'(res_valid), 64'd0);
        chk("release start_ready", 64'(start_ready), 64'd1);
        chk("release result kept", result, e.r);

        // Reset during RUN at slice index 2
        op_a = 64'h1111_2222_3333_4444; op_b = 64'h1; sub = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midrun reset result", result, 64'd0);
        chk("midrun reset res_valid", 64'(res_valid), 64'd0);
        chk("midrun reset start_ready", 64'(start_ready), 64'd1);
        chk("midrun reset flags", {62'd0, cout, ovf}, 64'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(64'h1234, 64'h0001, 1'b0, 1'b1, got, lat);
        chk("post-reset result", got.r, 64'h1235);
        chk("post-reset latency", 64'(lat), 64'd4);

        // Randomized isolated operations
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if (i % 4 == 1) rb = ~ra;
            if (i % 4 == 2) rb = ra;
            rs = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rs);
            run_op(ra, rb, rs, 1'b1, got, lat);
            chk($sformatf("rand%0d result", i), got.r, e.r);
            chk($sformatf("rand%0d flags", i), {62'd0, got.c, got.v}, {62'd0, e.c, e.v});
        end

        // Back-to-back with start_valid and res_ready held high
        last_acc = -1; n_acc = 0;
        res_ready = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            start_valid = (cyc < 40);
            op_a = {$urandom(), $urandom()};
            op_b = {$urandom(), $urandom()};
            sub  = 1'($urandom_range(0, 1));
            if (start_valid && start_ready) begin
                q.push_back(model(op_a, op_b, sub));
                if (last_acc >= 0) chk("b2b spacing", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                n_acc++;
            end
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk("b2b unexpected result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("b2b result", result, e.r);
                    chk("b2b flags", {62'd0, cout, ovf}, {62'd0, e.c, e.v});
                end
            end
            @(posedge clk); #1;
        end
        start_valid = 1'b0; res_ready = 1'b0;
        chk("b2b drained", 64'(q.size()), 64'd0);
        chk("b2b accept count", 64'(n_acc), 64'd7);

        // N_SLICES=1 instance: registered 16-bit add/sub
        for (int i = 0; i < 2; i++) begin
            s1_op_a = (i == 0) ? 16'h0003 : 16'h8000;
            s1_op_b = (i == 0) ? 16'h0004 : 16'h0001;
            s1_sub  = (i == 1);
            n = 0;
            while (!s1_start_ready && n < 20) begin
                @(posedge clk); #1; n++;
            end
            s1_start_valid = 1'b1;
            @(posedge clk); #1;
            s1_start_valid = 1'b0;
            lat = 0;
            while (!s1_res_valid && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            chk($sformatf("n1 op%0d latency", i), 64'(lat), 64'd1);
            chk($sformatf("n1 op%0d result", i), 64'(s1_result),
                (i == 0) ? 64'h0007 : 64'h7FFF);
            chk($sformatf("n1 op%0d flags", i), {62'd0, s1_cout, s1_ovf},
                (i == 0) ? 64'd0 : 64'd3);
            s1_res_ready = 1'b1;
            @(posedge clk); #1;
            s1_res_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
